// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-word-fall-through FIFO with clock enable and an occupancy
// count. The head word is always presented on rd_data straight from storage;
// a read request pops it on the clock edge.
//
// Writes while full and reads while empty are silently dropped and never
// disturb pointers, count or stored data. Fullness and emptiness are judged on
// the state before the edge. A write is therefore refused when the FIFO is full,
// even if a read in the same cycle would free a slot. A read is refused when the
// FIFO is empty, even if a write arrives in the same cycle.
//
// Parameters
//   SIZE        capacity in words (>= 2, need not be a power of two)
//   DATA_WIDTH  word width in bits
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, takes priority over ce
//   ce       in   clock enable; 0 holds every piece of state
//   wr_en    in   write request
//   wr_data  in   word to write
//   rd_en    in   read (pop) request
//   rd_data  out  head word; shows stale storage while empty
//   empty    out  count == 0
//   full     out  count == SIZE
//   count    out  number of stored words
//
// Optional build macro
//   SYNC_FIFO_CHECKS_EN  compiles in simulation-only overflow, underflow and
//                        count-range checks. The datapath is identical with or
//                        without the macro.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 4,
    localparam int CW        = $clog2(SIZE + 1),
    localparam int PW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count
);

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;

    // Flags come from the count register only, so they are purely registered
    // and cannot depend on this cycle's requests.
    assign w_full  = (r_count == CW'(SIZE));
    assign w_empty = (r_count == '0);

    assign w_wr_acc = ce && wr_en && !w_full;
    assign w_rd_acc = ce && rd_en && !w_empty;

    // Explicit wrap at SIZE-1 so that capacities that are not powers of two
    // work.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(SIZE - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(SIZE - 1)) ? '0 : r_rd_ptr + PW'(1);

    // ------------------------------------------------------------------
    // Pointer and count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_acc)
                r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory: contents are not reset. A write coinciding with reset is
    // blocked, so no word is written on the edge that empties the queue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc)
            r_mem[r_wr_ptr] <= wr_data;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data = r_mem[r_rd_ptr];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;

`ifdef SYNC_FIFO_CHECKS_EN
    // Simulation-only protocol checks.
    always_ff @(posedge clk) begin
        if (!rst && ce) begin
            if (wr_en && w_full)
                $error("sync_fifo: overflow, write dropped while full");
            if (rd_en && w_empty)
                $error("sync_fifo: underflow, read dropped while empty");
        end
        if (r_count > CW'(SIZE))
            $error("sync_fifo: count %0d exceeds SIZE %0d", r_count, SIZE);
    end
`else
    // Checks are not compiled. Dropped operations stay silent.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default SIZE=8, DATA_WIDTH=4
    logic       rst, ce, wr_en, rd_en;
    logic [3:0] wr_data, rd_data;
    logic       empty, full;
    logic [3:0] count;

    // DUT B: SIZE=5 for the pointer-wrap test
    logic       b_rst, b_ce, b_wr_en, b_rd_en;
    logic [3:0] b_wr_data, b_rd_data;
    logic       b_empty, b_full;
    logic [2:0] b_count;

    sync_fifo #(.SIZE(8), .DATA_WIDTH(4)) u_a (
        .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count)
    );

    sync_fifo #(.SIZE(5), .DATA_WIDTH(4)) u_b (
        .clk(clk), .rst(b_rst), .ce(b_ce), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .empty(b_empty), .full(b_full), .count(b_count)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: each FIFO is a plain queue of words.
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    // Drive one cycle on DUT A and apply the same request to the model.
    // Acceptance is decided from the occupancy before the edge.
    task automatic step_a(input logic c, input logic w, input logic [3:0] d, input logic r);
        bit do_w, do_r;
        ce = c; wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        if (rst) begin
            qa.delete();
        end else if (c) begin
            do_w = w && (qa.size() < 8);
            do_r = r && (qa.size() > 0);
            if (do_r) void'(qa.pop_front());
            if (do_w) qa.push_back(d);
        end
        #1;
    endtask

    task automatic step_b(input logic c, input logic w, input logic [3:0] d, input logic r);
        bit do_w, do_r;
        b_ce = c; b_wr_en = w; b_wr_data = d; b_rd_en = r;
        @(posedge clk);
        if (b_rst) begin
            qb.delete();
        end else if (c) begin
            do_w = w && (qb.size() < 5);
            do_r = r && (qb.size() > 0);
            if (do_r) void'(qb.pop_front());
            if (do_w) qb.push_back(d);
        end
        #1;
    endtask

    task automatic reset_a();
        rst = 1'b1;
        step_a(1'b1, 1'b0, 4'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        step_a(1'b1, 1'b0, 4'h0, 1'b0);
        step_b(1'b1, 1'b0, 4'h0, 1'b0);
        rst = 1'b0; b_rst = 1'b0;
        total_cnt++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0)
            $display("FAIL reset_a: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
        else pass_cnt++;
        total_cnt++;
        if (b_count !== 3'd0 || b_empty !== 1'b1 || b_full !== 1'b0)
            $display("FAIL reset_b: count=%0d empty=%b full=%b, want 0/1/0", b_count, b_empty, b_full);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        reset_a();
        for (int i = 0; i < 9; i++) begin
            step_a(1'b1, 1'b1, 4'(i), 1'b0);
            total_cnt++;
            if (count !== 4'((i < 8) ? i + 1 : 8) || full !== (i >= 7) || empty !== 1'b0)
                $display("FAIL fill[%0d]: count=%0d full=%b empty=%b, want count=%0d full=%b",
                         i, count, full, empty, (i < 8) ? i + 1 : 8, (i >= 7));
            else pass_cnt++;
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                total_cnt++;
                if (rd_data !== 4'(i))
                    $display("FAIL drain_data[%0d]: rd_data=%0h want %0h", i, rd_data, 4'(i));
                else pass_cnt++;
            end
            step_a(1'b1, 1'b0, 4'h0, 1'b1);
            total_cnt++;
            if (count !== 4'((i < 8) ? 7 - i : 0) || empty !== (i >= 7) || full !== 1'b0)
                $display("FAIL drain[%0d]: count=%0d empty=%b full=%b, want count=%0d empty=%b",
                         i, count, empty, full, (i < 8) ? 7 - i : 0, (i >= 7));
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        // count=3, push and pop together for 4 cycles
        reset_a();
        for (int i = 1; i <= 3; i++) step_a(1'b1, 1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (rd_data !== 4'(i + 1))
                $display("FAIL simul_order[%0d]: rd_data=%0h want %0h", i, rd_data, 4'(i + 1));
            else pass_cnt++;
            step_a(1'b1, 1'b1, 4'(i + 4), 1'b1);
            total_cnt++;
            if (count !== 4'd3)
                $display("FAIL simul_count[%0d]: count=%0d want 3", i, count);
            else pass_cnt++;
        end
        // full: the read happens, the write is dropped
        reset_a();
        for (int i = 0; i < 8; i++) step_a(1'b1, 1'b1, 4'(i + 2), 1'b0);
        step_a(1'b1, 1'b1, 4'hF, 1'b1);
        total_cnt++;
        if (count !== 4'd7 || full !== 1'b0 || rd_data !== 4'h3)
            $display("FAIL simul_full: count=%0d full=%b rd_data=%0h, want 7/0/3", count, full, rd_data);
        else pass_cnt++;
        // drain and confirm 0xF never entered
        for (int i = 0; i < 7; i++) begin
            total_cnt++;
            if (rd_data !== 4'(i + 3))
                $display("FAIL simul_full_drain[%0d]: rd_data=%0h want %0h", i, rd_data, 4'(i + 3));
            else pass_cnt++;
            step_a(1'b1, 1'b0, 4'h0, 1'b1);
        end
        total_cnt++;
        if (empty !== 1'b1)
            $display("FAIL simul_full_end: empty=%b want 1", empty);
        else pass_cnt++;
        // empty: the write happens, the read is dropped
        step_a(1'b1, 1'b1, 4'h9, 1'b1);
        total_cnt++;
        if (count !== 4'd1 || empty !== 1'b0 || rd_data !== 4'h9)
            $display("FAIL simul_empty: count=%0d empty=%b rd_data=%0h, want 1/0/9", count, empty, rd_data);
        else pass_cnt++;
    endtask

    task automatic test_ce();
        reset_a();
        step_a(1'b1, 1'b1, 4'h5, 1'b0);
        step_a(1'b1, 1'b1, 4'h6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step_a(1'b0, 1'b1, 4'(i + 10), 1'b1);
            total_cnt++;
            if (count !== 4'd2 || rd_data !== 4'h5 || empty !== 1'b0 || full !== 1'b0)
                $display("FAIL ce_hold[%0d]: count=%0d rd_data=%0h empty=%b full=%b, want 2/5/0/0",
                         i, count, rd_data, empty, full);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b1, 4'(i + 1), 1'b0);
        rst = 1'b1;
        step_a(1'b0, 1'b1, 4'h7, 1'b1);
        rst = 1'b0;
        total_cnt++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0)
            $display("FAIL reset_mid: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
        else pass_cnt++;
        step_a(1'b1, 1'b1, 4'hA, 1'b0);
        total_cnt++;
        if (rd_data !== 4'hA || count !== 4'd1)
            $display("FAIL reset_mid_write: rd_data=%0h count=%0d, want A/1", rd_data, count);
        else pass_cnt++;
    endtask

    // SIZE=5: random interleaving that keeps 1..5 words queued. Accepted
    // writes carry a running sequence number. Pops must return that sequence
    // in order, with nothing lost or duplicated.
    task automatic test_wrap();
        logic [3:0] wr_seq, rd_seq;
        bit w, r;
        int pops;
        wr_seq = 4'h0; rd_seq = 4'h0; pops = 0;
        step_b(1'b1, 1'b1, wr_seq, 1'b0);
        wr_seq++;
        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (qb.size() == 1 && !w) r = 1'b0;
            if (r) begin
                total_cnt++;
                if (b_rd_data !== rd_seq)
                    $display("FAIL wrap_order[%0d]: rd_data=%0h want %0h", i, b_rd_data, rd_seq);
                else pass_cnt++;
                rd_seq++;
                pops++;
            end
            if (w && qb.size() < 5) begin
                step_b(1'b1, 1'b1, wr_seq, r);
                wr_seq++;
            end else begin
                step_b(1'b1, w, 4'hF, r);
            end
            total_cnt++;
            if (b_count !== 3'(qb.size()) || b_full !== (qb.size() == 5) || b_empty !== 1'b0)
                $display("FAIL wrap_count[%0d]: count=%0d full=%b empty=%b, want count=%0d",
                         i, b_count, b_full, b_empty, qb.size());
            else pass_cnt++;
        end
        total_cnt++;
        if (pops < 12)
            $display("FAIL wrap_pops: pops=%0d want >=12", pops);
        else pass_cnt++;
    endtask

    // Random traffic on DUT A, including clock-enable gaps and occasional
    // resets. Every cycle is compared against the queue model.
    task automatic test_random();
        reset_a();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step_a($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                   4'($urandom), $urandom_range(0, 1) == 1);
            rst = 1'b0;
            total_cnt++;
            if (count !== 4'(qa.size()) || empty !== (qa.size() == 0) || full !== (qa.size() == 8))
                $display("FAIL rand_state[%0d]: count=%0d empty=%b full=%b, want count=%0d",
                         i, count, empty, full, qa.size());
            else pass_cnt++;
            if (qa.size() > 0) begin
                total_cnt++;
                if (rd_data !== qa[0])
                    $display("FAIL rand_data[%0d]: rd_data=%0h want %0h", i, rd_data, qa[0]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        b_rst = 1'b1; b_ce = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_ce();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
